jam_cost_server: RTL and testbench
==================================

Name: jam_cost_server

Overview:
- Responder end of the JAM cost-lookup interface: holds the 8x8 worker/job cost table and returns Cost for the W/J address driven by JAM.
- Table is streamed in row-major order over a valid/ready load port.
- Once loaded, the block releases JAM from reset and answers lookups with one-cycle latency.
- It captures MinCost/MatchCount on the first Valid and counts JAM run cycles and lookups.

Parameters:
- N_W, 8, number of workers (rows); address width is clog2(N_W).
- N_J, 8, number of jobs (columns); address width is clog2(N_J).
- COST_W, 7, cost entry width.
- CNT_W, 20, width of the cycle and lookup counters.

Ports:
- CLK  in  1  single clock; all logic on rising edge.
- RST  in  1  synchronous, active-low reset.
- LoadStart  in  1  one-cycle pulse; starts or restarts a table load.
- LoadValid  in  1  LoadData is valid this cycle.
- LoadData  in  COST_W  cost entry, row-major (W*N_J+J).
- LoadReady  out  1  high in LOAD state.
- JamRst  out  1  active-high reset to JAM; low only in RUN state.
- W  in  3  worker address from JAM.
- J  in  3  job address from JAM.
- Cost  out  COST_W  table[W][J] as sampled on the previous edge.
- Valid  in  1  JAM done strobe.
- MinCost  in  9  JAM result.
- MatchCount  in  4  JAM result.
- ResMinCost  out  9  captured MinCost.
- ResMatchCount  out  4  captured MatchCount.
- Done  out  1  result captured.
- CycleCount  out  CNT_W  cycles spent in RUN, saturating.
- LookupCount  out  CNT_W  lookups served, saturating.

Behaviour:
- Reset (RST=0 at an edge), effective that edge, including mid-load or mid-run:
  - state = IDLE; JamRst=1, LoadReady=0, Cost=0.
  - ResMinCost=0, ResMatchCount=0, Done=0, CycleCount=0, LookupCount=0.
  - Load index = 0; table contents are not cleared.
- FSM: IDLE -> LOAD -> HOLD -> RUN -> DONE.
  - IDLE: LoadStart -> LOAD; index cleared.
  - LOAD:
    - Each edge with LoadValid=1 writes LoadData to table[index], then index increments.
    - After the write of index N_W*N_J-1, go to HOLD; LoadReady drops the next cycle.
    - LoadValid with LoadReady=0 is ignored.
  - HOLD: keeps JamRst=1 for exactly 2 cycles, then goes to RUN, so JAM sees at least 2 reset cycles.
  - RUN:
    - JamRst=0; CycleCount increments every cycle.
    - Lookup capture: W and J are sampled at every edge, and Cost = table[W_s][J_s] (registered address with combinational read, or a registered read; the edge-relative timing is identical). Cost is valid from just after edge k until edge k+1 for the address presented at edge k.
    - Lookup counting: LookupCount increments when the sampled {W,J} differs from the previous sample, or on the first RUN cycle.
    - Valid=1: capture MinCost and MatchCount, set Done=1, go to DONE.
  - DONE:
    - Counters and results are frozen; further Valid is ignored; JamRst=1.
    - LoadStart -> LOAD, clearing Done, the counters and the results (a new pattern).
- LoadStart in LOAD, HOLD or RUN aborts and restarts the load:
  - index=0, JamRst=1.
  - Partially written entries keep their new values.
- Cost while not in RUN:
  - Holds the table read of the last sampled address.
  - In LOAD, a lookup of the entry being written the same edge returns the old value (read before write).
- Counters saturate at 2^CNT_W-1 and never wrap.
- Address out of range (when N_W or N_J is below 2^width): Cost=0.

Test Plan:
- Reset mid-load:
  - Assert RST=0 after 10 entries, release, then load all 64 entries, entry i=i mod 100.
  - Required: LoadReady drops after entry 63; JamRst high for 2 cycles then low.
  - Required: W=3, J=5 at edge k gives Cost=29 between edges k and k+1.
- Back-to-back lookups: in RUN, drive a new {W,J} every cycle for 64 cycles.
  - Required: each Cost matches the previous cycle's address; LookupCount=64.
- Repeated address: hold W=7, J=7 for 10 cycles.
  - Required: LookupCount increments once; Cost=table[63] throughout.
- Valid capture:
  - Pulse Valid with MinCost=311, MatchCount=2, then pulse Valid again with MinCost=5.
  - Required: Done=1, ResMinCost=311, ResMatchCount=2, JamRst=1, CycleCount frozen.
- Abort and reload: pulse LoadStart in RUN, then reload with all entries=127.
  - Required: JamRst=1 immediately, Done=0, counters=0; after reload, any lookup returns 127.
- Saturation: with CNT_W=4, stay in RUN for 20 cycles.
  - Required: CycleCount stops at 15.

Source files
------------

// File: rtl/jam_cost_server.sv
// rtl/jam_cost_server.sv - JAM cost-table responder: streamed table load, JAM reset sequencing, lookups, result capture
// Cost is a registered read, so a lookup of the entry written on the same edge returns the old value.
module jam_cost_server #(
  parameter int N_W    = 8,
  parameter int N_J    = 8,
  parameter int COST_W = 7,
  parameter int CNT_W  = 20
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     LoadStart,
  input  logic                     LoadValid,
  input  logic [COST_W-1:0]        LoadData,
  output logic                     LoadReady,
  output logic                     JamRst,
  input  logic [$clog2(N_W)-1:0]   W,
  input  logic [$clog2(N_J)-1:0]   J,
  output logic [COST_W-1:0]        Cost,
  input  logic                     Valid,
  input  logic [8:0]               MinCost,
  input  logic [3:0]               MatchCount,
  output logic [8:0]               ResMinCost,
  output logic [3:0]               ResMatchCount,
  output logic                     Done,
  output logic [CNT_W-1:0]         CycleCount,
  output logic [CNT_W-1:0]         LookupCount
);

  localparam int WW    = $clog2(N_W);
  localparam int JW    = $clog2(N_J);
  localparam int DEPTH = N_W * N_J;
  localparam int IW    = $clog2(DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_HOLD, S_RUN, S_DONE} state_t;

  state_t              state, state_n;
  logic [COST_W-1:0]   mem [DEPTH];
  logic [IW-1:0]       idx;
  logic                hold_cnt;
  logic [WW-1:0]       w_s;
  logic [JW-1:0]       j_s;
  logic                was_run;
  logic                in_range;
  logic [IW-1:0]       rd_addr;
  logic                wr_en;
  logic                addr_new;

  always_comb begin
    in_range = (int'(W) < N_W) && (int'(J) < N_J);
    rd_addr  = IW'(int'(W) * N_J + int'(J));
    wr_en    = (state == S_LOAD) && LoadValid && !LoadStart;
    addr_new = !was_run || (W != w_s) || (J != j_s);
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: if (LoadStart) state_n = S_LOAD;
      S_LOAD: begin
        if (LoadStart) state_n = S_LOAD;
        else if (LoadValid && idx == IW'(DEPTH - 1)) state_n = S_HOLD;
      end
      S_HOLD: begin
        if (LoadStart) state_n = S_LOAD;
        else if (hold_cnt) state_n = S_RUN;
      end
      S_RUN: begin
        if (LoadStart) state_n = S_LOAD;
        else if (Valid) state_n = S_DONE;
      end
      S_DONE: if (LoadStart) state_n = S_LOAD;
      default: state_n = S_IDLE;
    endcase
  end

  assign LoadReady = (state == S_LOAD);
  assign JamRst    = (state != S_RUN);

  // Table contents survive reset; only the load index is cleared.
  always_ff @(posedge CLK) begin
    if (wr_en) mem[idx] <= LoadData;
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state         <= S_IDLE;
      idx           <= '0;
      hold_cnt      <= 1'b0;
      w_s           <= '0;
      j_s           <= '0;
      was_run       <= 1'b0;
      Cost          <= '0;
      ResMinCost    <= '0;
      ResMatchCount <= '0;
      Done          <= 1'b0;
      CycleCount    <= '0;
      LookupCount   <= '0;
    end else begin
      state    <= state_n;
      w_s      <= W;
      j_s      <= J;
      was_run  <= (state == S_RUN);
      Cost     <= in_range ? mem[rd_addr] : '0;
      hold_cnt <= (state == S_HOLD) ? ~hold_cnt : 1'b0;

      if (LoadStart) begin
        idx           <= '0;
        Done          <= 1'b0;
        ResMinCost    <= '0;
        ResMatchCount <= '0;
        CycleCount    <= '0;
        LookupCount   <= '0;
      end else begin
        if (wr_en) idx <= idx + 1'b1;
        if (state == S_RUN) begin
          if (CycleCount != '1) CycleCount <= CycleCount + 1'b1;
          if (addr_new && LookupCount != '1) LookupCount <= LookupCount + 1'b1;
          if (Valid) begin
            ResMinCost    <= MinCost;
            ResMatchCount <= MatchCount;
            Done          <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_jam_cost_server.sv
// tb/tb_jam_cost_server.sv - scoreboard bench for jam_cost_server
// A second instance with 4-bit counters shares all inputs to exercise saturation.
module tb_jam_cost_server;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        LoadStart = 1'b0;
  logic        LoadValid = 1'b0;
  logic [6:0]  LoadData = '0;
  logic [2:0]  W = '0;
  logic [2:0]  J = '0;
  logic        Valid = 1'b0;
  logic [8:0]  MinCost = '0;
  logic [3:0]  MatchCount = '0;

  logic        LoadReady, JamRst, Done;
  logic [6:0]  Cost;
  logic [8:0]  ResMinCost;
  logic [3:0]  ResMatchCount;
  logic [19:0] CycleCount, LookupCount;

  logic        s_LoadReady, s_JamRst, s_Done;
  logic [6:0]  s_Cost;
  logic [8:0]  s_ResMinCost;
  logic [3:0]  s_ResMatchCount;
  logic [3:0]  s_CycleCount, s_LookupCount;

  jam_cost_server dut (
    .CLK(CLK), .RST(RST), .LoadStart(LoadStart), .LoadValid(LoadValid), .LoadData(LoadData),
    .LoadReady(LoadReady), .JamRst(JamRst), .W(W), .J(J), .Cost(Cost), .Valid(Valid),
    .MinCost(MinCost), .MatchCount(MatchCount), .ResMinCost(ResMinCost),
    .ResMatchCount(ResMatchCount), .Done(Done), .CycleCount(CycleCount), .LookupCount(LookupCount)
  );

  jam_cost_server #(.CNT_W(4)) dut4 (
    .CLK(CLK), .RST(RST), .LoadStart(LoadStart), .LoadValid(LoadValid), .LoadData(LoadData),
    .LoadReady(s_LoadReady), .JamRst(s_JamRst), .W(W), .J(J), .Cost(s_Cost), .Valid(Valid),
    .MinCost(MinCost), .MatchCount(MatchCount), .ResMinCost(s_ResMinCost),
    .ResMatchCount(s_ResMatchCount), .Done(s_Done), .CycleCount(s_CycleCount), .LookupCount(s_LookupCount)
  );

  always #5 CLK = ~CLK;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [6:0] tb_mem [64];
  logic [6:0] exp_q [$];
  logic [6:0] exp_c;
  int         exp_cycles = 0;
  int         exp_lookups = 0;
  int         prev_addr = 0;
  bit         in_run = 1'b0;
  bit         first_run = 1'b0;

  // Advances one rising edge, updating the counter model for RUN edges.
  task automatic tick();
    if (in_run) begin
      exp_cycles++;
      if (first_run || int'({W, J}) != prev_addr) exp_lookups++;
      prev_addr = int'({W, J});
      first_run = 1'b0;
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic pulse_start();
    LoadStart = 1'b1;
    in_run = 1'b0;
    exp_cycles = 0;
    exp_lookups = 0;
    tick();
    LoadStart = 1'b0;
  endtask

  task automatic load_table(input int all127);
    for (int i = 0; i < 64; i++) begin
      LoadValid = 1'b1;
      LoadData = all127 ? 7'd127 : 7'(i % 100);
      tb_mem[i] = LoadData;
      tick();
    end
    LoadValid = 1'b0;
    tick();
    tick();
    in_run = 1'b1;
    first_run = 1'b1;
  endtask

  task automatic test_reset();
    RST = 1'b0;
    tick();
    tick();
    n_cmp++; if (LoadReady !== 1'b0) begin n_bad++; $display("FAIL reset_loadready got %0b want 0", LoadReady); end
    n_cmp++; if (JamRst !== 1'b1) begin n_bad++; $display("FAIL reset_jamrst got %0b want 1", JamRst); end
    n_cmp++; if (Cost !== 7'd0) begin n_bad++; $display("FAIL reset_cost got %0d want 0", Cost); end
    n_cmp++; if ({Done, ResMinCost, ResMatchCount} !== 14'd0) begin n_bad++; $display("FAIL reset_results got %0b/%0d/%0d want 0", Done, ResMinCost, ResMatchCount); end
    n_cmp++; if (CycleCount !== 20'd0 || LookupCount !== 20'd0) begin n_bad++; $display("FAIL reset_counts got %0d/%0d want 0/0", CycleCount, LookupCount); end
    RST = 1'b1;
  endtask

  task automatic test_reset_mid_load();
    pulse_start();
    for (int i = 0; i < 10; i++) begin
      LoadValid = 1'b1;
      LoadData = 7'(i);
      tb_mem[i] = LoadData;
      tick();
    end
    LoadValid = 1'b0;
    RST = 1'b0;
    tick();
    RST = 1'b1;
    n_cmp++; if (LoadReady !== 1'b0 || JamRst !== 1'b1) begin n_bad++; $display("FAIL midload_reset got ready=%0b jamrst=%0b want 0/1", LoadReady, JamRst); end
    pulse_start();
    for (int i = 0; i < 64; i++) begin
      LoadValid = 1'b1;
      LoadData = 7'(i % 100);
      tb_mem[i] = LoadData;
      tick();
      n_cmp++; if (LoadReady !== (i < 63)) begin n_bad++; $display("FAIL load_ready_%0d got %0b want %0b", i, LoadReady, i < 63); end
    end
    LoadValid = 1'b0;
    n_cmp++; if (JamRst !== 1'b1) begin n_bad++; $display("FAIL hold1_jamrst got %0b want 1", JamRst); end
    tick();
    n_cmp++; if (JamRst !== 1'b1) begin n_bad++; $display("FAIL hold2_jamrst got %0b want 1", JamRst); end
    tick();
    n_cmp++; if (JamRst !== 1'b0) begin n_bad++; $display("FAIL run_jamrst got %0b want 0", JamRst); end
    in_run = 1'b1;
    first_run = 1'b1;
    W = 3'd3; J = 3'd5;
    exp_q.push_back(7'd29);
    tick();
    exp_c = exp_q.pop_front();
    n_cmp++; if (Cost !== exp_c) begin n_bad++; $display("FAIL lookup_3_5 got %0d want %0d", Cost, exp_c); end
    n_cmp++; if (CycleCount !== 20'(exp_cycles) || LookupCount !== 20'(exp_lookups)) begin n_bad++; $display("FAIL first_counts got %0d/%0d want %0d/%0d", CycleCount, LookupCount, exp_cycles, exp_lookups); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 64; i++) begin
      W = i[5:3]; J = i[2:0];
      exp_q.push_back(tb_mem[i]);
      tick();
      if (exp_q.size() == 0) begin n_cmp++; n_bad++; $display("FAIL b2b_queue got empty want entry"); end
      else begin
        exp_c = exp_q.pop_front();
        n_cmp++; if (Cost !== exp_c) begin n_bad++; $display("FAIL b2b_cost_%0d got %0d want %0d", i, Cost, exp_c); end
      end
    end
    n_cmp++; if (LookupCount !== 20'(exp_lookups)) begin n_bad++; $display("FAIL b2b_lookups got %0d want %0d", LookupCount, exp_lookups); end
    n_cmp++; if (CycleCount !== 20'(exp_cycles)) begin n_bad++; $display("FAIL b2b_cycles got %0d want %0d", CycleCount, exp_cycles); end
    n_cmp++; if (s_CycleCount !== 4'd15) begin n_bad++; $display("FAIL sat_cycles got %0d want 15", s_CycleCount); end
    n_cmp++; if (s_LookupCount !== 4'd15) begin n_bad++; $display("FAIL sat_lookups got %0d want 15", s_LookupCount); end
  endtask

  task automatic test_repeated();
    W = 3'd7; J = 3'd7;
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back(tb_mem[63]);
      tick();
      exp_c = exp_q.pop_front();
      n_cmp++; if (Cost !== exp_c) begin n_bad++; $display("FAIL repeat_cost_%0d got %0d want %0d", i, Cost, exp_c); end
    end
    n_cmp++; if (LookupCount !== 20'(exp_lookups)) begin n_bad++; $display("FAIL repeat_lookups got %0d want %0d", LookupCount, exp_lookups); end
  endtask

  task automatic test_valid_capture();
    Valid = 1'b1; MinCost = 9'd311; MatchCount = 4'd2;
    tick();
    in_run = 1'b0;
    Valid = 1'b0;
    n_cmp++; if (Done !== 1'b1 || JamRst !== 1'b1) begin n_bad++; $display("FAIL capture_done got done=%0b jamrst=%0b want 1/1", Done, JamRst); end
    n_cmp++; if (ResMinCost !== 9'd311 || ResMatchCount !== 4'd2) begin n_bad++; $display("FAIL capture_result got %0d/%0d want 311/2", ResMinCost, ResMatchCount); end
    Valid = 1'b1; MinCost = 9'd5; MatchCount = 4'd9;
    W = 3'd1; J = 3'd2;
    tick();
    Valid = 1'b0;
    tick();
    tick();
    n_cmp++; if (ResMinCost !== 9'd311 || ResMatchCount !== 4'd2) begin n_bad++; $display("FAIL second_valid got %0d/%0d want 311/2", ResMinCost, ResMatchCount); end
    n_cmp++; if (CycleCount !== 20'(exp_cycles) || LookupCount !== 20'(exp_lookups)) begin n_bad++; $display("FAIL frozen_counts got %0d/%0d want %0d/%0d", CycleCount, LookupCount, exp_cycles, exp_lookups); end
  endtask

  task automatic test_abort_reload();
    pulse_start();
    n_cmp++; if (Done !== 1'b0 || ResMinCost !== 9'd0) begin n_bad++; $display("FAIL restart_clear got done=%0b res=%0d want 0/0", Done, ResMinCost); end
    load_table(0);
    for (int i = 0; i < 4; i++) begin
      W = 3'($urandom_range(0, 7)); J = 3'($urandom_range(0, 7));
      exp_q.push_back(tb_mem[{W, J}]);
      tick();
      exp_c = exp_q.pop_front();
      n_cmp++; if (Cost !== exp_c) begin n_bad++; $display("FAIL rerun_cost_%0d got %0d want %0d", i, Cost, exp_c); end
    end
    pulse_start();
    n_cmp++; if (JamRst !== 1'b1 || LoadReady !== 1'b1 || Done !== 1'b0) begin n_bad++; $display("FAIL abort_state got jamrst=%0b ready=%0b done=%0b want 1/1/0", JamRst, LoadReady, Done); end
    n_cmp++; if (CycleCount !== 20'd0 || LookupCount !== 20'd0) begin n_bad++; $display("FAIL abort_counts got %0d/%0d want 0/0", CycleCount, LookupCount); end
    for (int i = 0; i < 64; i++) begin
      LoadValid = 1'b1; LoadData = 7'd127;
      W = i[5:3]; J = i[2:0];
      exp_q.push_back(tb_mem[i]);
      tb_mem[i] = 7'd127;
      tick();
      exp_c = exp_q.pop_front();
      n_cmp++; if (Cost !== exp_c) begin n_bad++; $display("FAIL rbw_cost_%0d got %0d want %0d", i, Cost, exp_c); end
    end
    LoadData = 7'd0;
    tick();
    tick();
    in_run = 1'b1;
    first_run = 1'b1;
    for (int i = 0; i < 6; i++) begin
      W = 3'($urandom_range(0, 7)); J = 3'($urandom_range(0, 7));
      if (i == 0) begin W = 3'd0; J = 3'd0; end
      exp_q.push_back(tb_mem[{W, J}]);
      tick();
      exp_c = exp_q.pop_front();
      n_cmp++; if (Cost !== exp_c) begin n_bad++; $display("FAIL reload_cost_%0d got %0d want %0d", i, Cost, exp_c); end
    end
    LoadValid = 1'b0;
    n_cmp++; if (LookupCount !== 20'(exp_lookups) || CycleCount !== 20'(exp_cycles)) begin n_bad++; $display("FAIL reload_counts got %0d/%0d want %0d/%0d", LookupCount, CycleCount, exp_lookups, exp_cycles); end
  endtask

  initial begin
    test_reset();
    test_reset_mid_load();
    test_back_to_back();
    test_repeated();
    test_valid_capture();
    test_abort_reload();
    if (exp_q.size() != 0) begin n_cmp++; n_bad++; $display("FAIL scoreboard_leftover got %0d want 0", exp_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "timeout");
  end

endmodule
